// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Registered IDLE/BUSY/DONE handshake controller with multi-cycle latency and a fetch-starvation guard.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  parameter int DATA_BASE  = 88
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(1);
  localparam logic [CNT_W-1:0]  STARVE_TOP = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] BASE_OFS   = ADDR_W'(DATA_BASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              own_data_q, own_data_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              fetch_win_s;
  logic              if_gnt_s;
  logic              d_gnt_s;

  always_comb begin
    fetch_win_s  = if_req && (!d_req || (starve_q == STARVE_TOP));
    if_gnt_s     = 1'b0;
    d_gnt_s      = 1'b0;
    state_d      = state_q;
    starve_d     = starve_q;
    lat_d        = lat_q;
    own_data_d   = own_data_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    mem_funct3_d = mem_funct3_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_win_s) begin
          if_gnt_s     = 1'b1;
          starve_d     = {CNT_W{1'b0}};
          own_data_d   = 1'b0;
          mem_re_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_funct3_d = 3'b010;
          mem_addr_d   = if_addr;
          mem_wdata_d  = {DATA_W{1'b0}};
          lat_d        = LAT_INIT;
          state_d      = S_BUSY;
        end else if (d_req) begin
          d_gnt_s      = 1'b1;
          // Only a grant that actually made fetch wait counts towards starvation.
          if (if_req && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + 1'b1;
          end else begin
            starve_d = starve_q;
          end
          own_data_d   = 1'b1;
          mem_re_d     = !d_we;
          mem_we_d     = d_we;
          mem_funct3_d = d_funct3;
          mem_addr_d   = d_addr + BASE_OFS;
          mem_wdata_d  = d_wdata;
          lat_d        = LAT_INIT;
          state_d      = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LAT_LAST) begin
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_DONE;
          if (own_data_q) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      starve_q     <= {CNT_W{1'b0}};
      lat_q        <= {LAT_W{1'b0}};
      own_data_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_funct3_q <= 3'b000;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      own_data_q   <= own_data_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_funct3_q <= mem_funct3_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Grants come straight from arbitration; masking with rst keeps them low while reset is held.
  assign if_gnt     = if_gnt_s & rst;
  assign d_gnt      = d_gnt_s & rst;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_rdata    = d_rdata_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_funct3 = mem_funct3_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with a shadow memory.
module tb_unified_mem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;
  localparam int BASE = 88;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]    d_funct3;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_re, mem_we, busy;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic          pre_en;
  logic [AW-1:0] pre_addr;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX), .DATA_BASE(BASE)
  ) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h04) return 32'h00500093;
    return {a, 8'h5A, ~a, a ^ 8'hC3};
  endfunction

  // Memory model: combinational read, write on the clock edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_en) mem[pre_addr] <= init_val(pre_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h00; d_req = 1'b1; d_we = 1'b0;
    d_funct3 = 3'b000; d_addr = 8'h00; d_wdata = 32'h0; pre_en = 1'b1; pre_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      pre_addr = 8'(i);
      ref_mem[i] = init_val(8'(i));
      tick();
    end
    pre_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt got %b exp 00", {if_gnt, d_gnt});
    end
    n_tests++;
    if ({mem_re, mem_we, mem_funct3, mem_addr, mem_wdata} !== 45'h0) begin
      n_fail++; $display("FAIL reset_mem got %h exp 0", {mem_re, mem_we, mem_funct3, mem_addr, mem_wdata});
    end
    n_tests++;
    if ({if_rvalid, d_rvalid, if_rdata, d_rdata, busy} !== 67'h0) begin
      n_fail++; $display("FAIL reset_resp got %h exp 0", {if_rvalid, d_rvalid, if_rdata, d_rdata, busy});
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only();
    if_addr = 8'h04; if_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({if_gnt, d_gnt, busy} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_gnt got %b exp 100", {if_gnt, d_gnt, busy});
    end
    tick();
    if_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_re, mem_we, mem_addr, mem_funct3, busy, if_rvalid} !== {1'b1, 1'b0, 8'h04, 3'b010, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL fetch_bus k=%0d got re=%b we=%b addr=%h f3=%b rv=%b", k, mem_re, mem_we, mem_addr, mem_funct3, if_rvalid);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({if_rvalid, if_rdata, mem_re, busy} !== {1'b1, 32'h00500093, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fetch_rvalid got rv=%b data=%h re=%b exp rv=1 data=00500093", if_rvalid, if_rdata, mem_re);
    end
    @(negedge clk);
    n_tests++;
    if ({if_rvalid, busy, if_rdata} !== {1'b0, 1'b0, 32'h00500093}) begin
      n_fail++; $display("FAIL fetch_hold got rv=%b busy=%b data=%h", if_rvalid, busy, if_rdata);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 8'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00; d_funct3 = 3'b010;
    @(negedge clk);
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL sim_first got if/d=%b exp 01", {if_gnt, d_gnt});
    end
    tick();
    d_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_re, mem_addr, if_gnt} !== {1'b1, 8'd88, 1'b0}) begin
        n_fail++; $display("FAIL sim_bus k=%0d got re=%b addr=%0d ig=%b exp re=1 addr=88", k, mem_re, mem_addr, if_gnt);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({d_rvalid, d_rdata, if_gnt} !== {1'b1, init_val(8'd88), 1'b0}) begin
      n_fail++; $display("FAIL sim_drvalid got rv=%b data=%h ig=%b exp data=%h", d_rvalid, d_rdata, if_gnt, init_val(8'd88));
    end
    @(negedge clk);
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL sim_second got if/d=%b exp 10", {if_gnt, d_gnt});
    end
    tick();
    if_req = 1'b0;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h04; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    @(negedge clk);
    n_tests++;
    if (d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL store_gnt got %b exp 1", d_gnt);
    end
    tick();
    d_req = 1'b0; d_we = 1'b0;
    ref_mem[92] = 32'hDEADBEEF;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_we, mem_re, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'd92, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL store_bus k=%0d got we=%b re=%b addr=%0d wd=%h", k, mem_we, mem_re, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({d_rvalid, d_rdata, mem_we} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL store_rvalid got rv=%b data=%h we=%b exp rv=1 data=0", d_rvalid, d_rdata, mem_we);
    end
    tick();
  endtask

  task automatic test_starvation();
    int ng = 0;
    int last_g = 0;
    bit exp_f;
    if_req = 1'b1; if_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; d_funct3 = 3'b000;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        exp_f = (ng % 5 == 4);
        n_tests++;
        if ({if_gnt, d_gnt} !== {exp_f, !exp_f}) begin
          n_fail++; $display("FAIL starve_order grant=%0d got if/d=%b exp %b", ng, {if_gnt, d_gnt}, {exp_f, !exp_f});
        end
        if (ng > 0) begin
          n_tests++;
          if (cyc - last_g != LAT + 2) begin
            n_fail++; $display("FAIL starve_spacing grant=%0d got %0d exp %0d", ng, cyc - last_g, LAT + 2);
          end
        end
        last_g = cyc;
        ng++;
      end
      tick();
    end
    n_tests++;
    if (ng != 10) begin
      n_fail++; $display("FAIL starve_count got %0d grants exp 10", ng);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 3) tick();
  endtask

  task automatic test_wrap();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'hB0; d_funct3 = 3'b100;
    @(negedge clk);
    n_tests++;
    if (d_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wrap_gnt got %b exp 1", d_gnt);
    end
    tick();
    d_req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_re, mem_addr, mem_funct3, d_rvalid} !== {1'b1, 8'h08, 3'b100, 1'b0}) begin
        n_fail++; $display("FAIL wrap_bus k=%0d got re=%b addr=%h f3=%b rv=%b exp addr=08", k, mem_re, mem_addr, mem_funct3, d_rvalid);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, init_val(8'h08), 1'b0}) begin
      n_fail++; $display("FAIL wrap_rvalid got rv=%b data=%h exp data=%h", d_rvalid, d_rdata, init_val(8'h08));
    end
    tick();
  endtask

  task automatic test_async_reset();
    if_req = 1'b1; if_addr = 8'h40;
    @(negedge clk);
    n_tests++;
    if (if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL areset_gnt got %b exp 1", if_gnt);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({if_gnt, d_gnt, mem_re, mem_we, mem_funct3, mem_addr, mem_wdata, if_rvalid, d_rvalid, if_rdata, d_rdata, busy} !== 113'h0) begin
      n_fail++; $display("FAIL areset_outputs got re=%b busy=%b ig=%b addr=%h rdata=%h exp all 0", mem_re, busy, if_gnt, mem_addr, if_rdata);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({if_gnt, if_rvalid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL areset_regrant got gnt/rv/busy=%b exp 100", {if_gnt, if_rvalid, busy});
    end
    tick();
    if_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    n_tests++;
    if ({if_rvalid, if_rdata} !== {1'b1, init_val(8'h40)}) begin
      n_fail++; $display("FAIL areset_fresh got rv=%b data=%h exp data=%h", if_rvalid, if_rdata, init_val(8'h40));
    end
    tick();
  endtask

  task automatic test_random();
    bit            have = 1'b0;
    int            g_cyc = 0;
    int            k;
    int            starve = 0;
    bit            own_d = 1'b0;
    logic          re_m = 1'b0, we_m = 1'b0;
    logic [2:0]    f3_m = 3'b000;
    logic [AW-1:0] addr_m = 8'h00;
    logic [DW-1:0] wd_m = 32'h0, rd_m = 32'h0;
    logic [DW-1:0] last_if = 32'h0, last_d = 32'h0;
    logic          e_ig, e_dg, e_re, e_we, e_irv, e_drv, e_busy;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    tick();
    rst = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      e_ig = 1'b0; e_dg = 1'b0; e_re = 1'b0; e_we = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_busy = 1'b0;
      if (have) begin
        k = cyc - g_cyc;
        e_busy = 1'b1;
        if (k <= LAT) begin
          e_re = re_m; e_we = we_m;
        end else begin
          if (own_d) begin e_drv = 1'b1; last_d = rd_m; end
          else begin e_irv = 1'b1; last_if = rd_m; end
          have = 1'b0;
        end
      end else if (if_req && (!d_req || starve == SMAX)) begin
        e_ig = 1'b1; starve = 0; have = 1'b1; g_cyc = cyc; own_d = 1'b0;
        re_m = 1'b1; we_m = 1'b0; f3_m = 3'b010; addr_m = if_addr; rd_m = ref_mem[if_addr];
      end else if (d_req) begin
        e_dg = 1'b1; have = 1'b1; g_cyc = cyc; own_d = 1'b1;
        if (if_req && starve < SMAX) starve++;
        re_m = !d_we; we_m = d_we; f3_m = d_funct3; wd_m = d_wdata;
        addr_m = 8'((int'(d_addr) + BASE) % 256);
        if (d_we) begin ref_mem[addr_m] = d_wdata; rd_m = 32'h0; end
        else rd_m = ref_mem[addr_m];
      end
      n_tests++;
      if ({if_gnt, d_gnt} !== {e_ig, e_dg}) begin
        n_fail++; $display("FAIL rnd_gnt cyc=%0d got %b exp %b", cyc, {if_gnt, d_gnt}, {e_ig, e_dg});
      end
      n_tests++;
      if ({mem_re, mem_we, busy} !== {e_re, e_we, e_busy}) begin
        n_fail++; $display("FAIL rnd_ctl cyc=%0d got re/we/busy=%b exp %b", cyc, {mem_re, mem_we, busy}, {e_re, e_we, e_busy});
      end
      if (e_re || e_we) begin
        n_tests++;
        if ({mem_addr, mem_funct3} !== {addr_m, f3_m} || (e_we && mem_wdata !== wd_m)) begin
          n_fail++; $display("FAIL rnd_cmd cyc=%0d got addr=%h f3=%b wd=%h exp addr=%h f3=%b wd=%h", cyc, mem_addr, mem_funct3, mem_wdata, addr_m, f3_m, wd_m);
        end
      end
      n_tests++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {e_irv, e_drv, last_if, last_d}) begin
        n_fail++; $display("FAIL rnd_resp cyc=%0d got rv=%b if=%h d=%h exp rv=%b if=%h d=%h", cyc, {if_rvalid, d_rvalid}, if_rdata, d_rdata, {e_irv, e_drv}, last_if, last_d);
      end
      tick();
      if (e_ig || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0); if_addr = 8'($urandom_range(0, 63));
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (e_dg || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
        d_addr = 8'(8'hB8 + $urandom_range(0, 31)); d_wdata = $urandom; d_funct3 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_store();
    test_starvation();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached with %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
